// File: rtl/cvxif_mac_pkg.sv
// rtl/cvxif_mac_pkg.sv - shared types for the CV-X-IF multiply-accumulate coprocessor
package cvxif_mac_pkg;

  localparam logic [6:0] MAC_OPCODE = 7'h0B;

  typedef enum logic [2:0] {
    OP_MAC = 3'b000,
    OP_RDL = 3'b001,
    OP_RDH = 3'b010,
    OP_CLR = 3'b011
  } mac_op_e;

  // Control half of a buffer entry; id and operands live in parallel arrays
  // so this type stays independent of XLEN/ID_W.
  typedef struct packed {
    logic       committed;
    logic       killed;
    logic [4:0] rd;
    mac_op_e    op;
    logic [1:0] acc;
  } mac_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_RESP
  } mac_state_e;

  function automatic logic is_read(input mac_op_e op);
    return (op == OP_RDL) || (op == OP_RDH);
  endfunction

endpackage

// File: rtl/cvxif_mac_if.sv
// rtl/cvxif_mac_if.sv - issue/commit/result channels between core (master) and coprocessor (slave)
interface cvxif_mac_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);

  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_instr;
  logic [ID_W-1:0] issue_id;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic            issue_accept;
  logic            issue_writeback;

  logic            commit_valid;
  logic [ID_W-1:0] commit_id;
  logic            commit_kill;

  logic            result_valid;
  logic            result_ready;
  logic [ID_W-1:0] result_id;
  logic [XLEN-1:0] result_data;
  logic [4:0]      result_rd;
  logic            result_we;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2,
    output commit_valid, commit_id, commit_kill, result_ready,
    input  issue_ready, issue_accept, issue_writeback,
    input  result_valid, result_id, result_data, result_rd, result_we
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2,
    input  commit_valid, commit_id, commit_kill, result_ready,
    output issue_ready, issue_accept, issue_writeback,
    output result_valid, result_id, result_data, result_rd, result_we
  );

endinterface

// File: rtl/cvxif_mac_datapath.sv
// rtl/cvxif_mac_datapath.sv - product register and accumulator file
// CVXIF_MAC_SAT_EN defined: MAC saturates on signed overflow; undefined: MAC wraps.
module cvxif_mac_datapath
  import cvxif_mac_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NR_ACC = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mul_en,
  input  logic            acc_en,
  input  mac_op_e         op,
  input  logic [1:0]      acc_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd_data
);

  localparam int AW    = 2 * XLEN;
  localparam int ACC_W = (NR_ACC > 1) ? $clog2(NR_ACC) : 1;

  logic [ACC_W-1:0] sel;
  logic [AW-1:0]    rs1_ext, rs2_ext;
  logic [AW-1:0]    prod_q;
  logic [AW-1:0]    acc_q [NR_ACC];
  logic [AW-1:0]    acc_cur, sum, mac_val;

  assign sel     = ACC_W'(acc_sel) & ACC_W'(NR_ACC - 1);
  // Low 2*XLEN bits of the product of sign-extended operands equal the signed product.
  assign rs1_ext = {{XLEN{rs1[XLEN-1]}}, rs1};
  assign rs2_ext = {{XLEN{rs2[XLEN-1]}}, rs2};
  assign acc_cur = acc_q[sel];
  assign sum     = acc_cur + prod_q;

`ifdef CVXIF_MAC_SAT_EN
  logic ovf;
  assign ovf     = (acc_cur[AW-1] == prod_q[AW-1]) && (sum[AW-1] != acc_cur[AW-1]);
  assign mac_val = ovf ? {acc_cur[AW-1], {(AW-1){~acc_cur[AW-1]}}} : sum;
`else
  assign mac_val = sum;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      for (int i = 0; i < NR_ACC; i++) acc_q[i] <= '0;
    end else begin
      if (mul_en) prod_q <= rs1_ext * rs2_ext;
      if (acc_en) begin
        case (op)
          OP_MAC:  acc_q[sel] <= mac_val;
          OP_CLR:  acc_q[sel] <= '0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (op)
      OP_RDL:  rd_data = acc_cur[XLEN-1:0];
      OP_RDH:  rd_data = acc_cur[AW-1:XLEN];
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/cvxif_mac_copro.sv
// rtl/cvxif_mac_copro.sv - CV-X-IF MAC coprocessor: decode, in-flight buffer, commit matching, FSM, result channel
module cvxif_mac_copro
  import cvxif_mac_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NR_ACC = 4,
  parameter int DEPTH  = 4,
  parameter int ID_W   = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  cvxif_mac_if.slave cvxif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       dec_accept;
  logic       unused_instr;

  assign opcode       = cvxif.issue_instr[6:0];
  assign funct3       = cvxif.issue_instr[14:12];
  assign funct7       = cvxif.issue_instr[31:25];
  assign dec_accept   = (opcode == MAC_OPCODE) && (funct7[6:2] == 5'd0) && !funct3[2];
  assign unused_instr = ^cvxif.issue_instr[24:15];

  assign cvxif.issue_accept    = dec_accept;
  assign cvxif.issue_writeback = dec_accept && is_read(mac_op_e'(funct3));

  mac_entry_t      ent_q [DEPTH];
  logic [ID_W-1:0] id_q  [DEPTH];
  logic [XLEN-1:0] rs1_q [DEPTH];
  logic [XLEN-1:0] rs2_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic            ready_q;
  mac_state_e      state_q;
  mac_entry_t      head_ent;
  logic            head_live, push, pop;

  logic            res_valid_q, res_we_q;
  logic [ID_W-1:0] res_id_q;
  logic [XLEN-1:0] res_data_q, dp_rd_data;
  logic [4:0]      res_rd_q;

  assign head_ent   = ent_q[head_q];
  assign head_live  = (count_q != '0);
  assign push       = cvxif.issue_valid && ready_q && dec_accept;
  assign pop        = ((state_q == S_IDLE) && head_live && head_ent.committed && head_ent.killed)
                   || ((state_q == S_RESP) && cvxif.result_ready);
  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  // Commits arrive in order, so only the oldest unresolved entry can match.
  logic             cm_hit, cm_seen;
  logic [PTR_W-1:0] cm_idx, scan_idx;
  always_comb begin
    cm_hit   = 1'b0;
    cm_seen  = 1'b0;
    cm_idx   = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (!cm_seen && (CNT_W'(i) < count_q) && !ent_q[scan_idx].committed) begin
        cm_seen = 1'b1;
        cm_idx  = scan_idx;
        cm_hit  = cvxif.commit_valid && (id_q[scan_idx] == cvxif.commit_id);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q] <= '{committed: 1'b0, killed: 1'b0, rd: cvxif.issue_instr[11:7],
                           op: mac_op_e'(funct3), acc: funct7[1:0]};
        tail_q <= tail_q + 1'b1;
      end
      if (cm_hit) begin
        ent_q[cm_idx].committed <= 1'b1;
        ent_q[cm_idx].killed    <= cvxif.commit_kill;
      end
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_next;
      ready_q <= (count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[tail_q]  <= cvxif.issue_id;
      rs1_q[tail_q] <= cvxif.issue_rs1;
      rs2_q[tail_q] <= cvxif.issue_rs2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (head_live && head_ent.committed && !head_ent.killed) state_q <= S_MUL;
        S_MUL:  state_q <= S_ACC;
        S_ACC: begin
          state_q     <= S_RESP;
          res_valid_q <= 1'b1;
          res_id_q    <= id_q[head_q];
          res_data_q  <= dp_rd_data;
          res_rd_q    <= head_ent.rd;
          res_we_q    <= is_read(head_ent.op);
        end
        S_RESP: if (cvxif.result_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  cvxif_mac_datapath #(.XLEN(XLEN), .NR_ACC(NR_ACC)) u_datapath (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .mul_en  (state_q == S_MUL),
    .acc_en  (state_q == S_ACC),
    .op      (head_ent.op),
    .acc_sel (head_ent.acc),
    .rs1     (rs1_q[head_q]),
    .rs2     (rs2_q[head_q]),
    .rd_data (dp_rd_data)
  );

  assign cvxif.issue_ready  = ready_q;
  assign cvxif.result_valid = res_valid_q;
  assign cvxif.result_id    = res_id_q;
  assign cvxif.result_data  = res_data_q;
  assign cvxif.result_rd    = res_rd_q;
  assign cvxif.result_we    = res_we_q;

  a_commit_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cvxif.commit_valid |-> cm_hit);

endmodule

// File: tb/tb_cvxif_mac_copro.sv
// tb/tb_cvxif_mac_copro.sv - scoreboard bench for cvxif_mac_copro; expectations follow CVXIF_MAC_SAT_EN
module tb_cvxif_mac_copro;

  localparam logic [2:0] F_MAC = 3'd0, F_RDL = 3'd1, F_RDH = 3'd2, F_CLR = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cvxif_mac_if #(.XLEN(32), .ID_W(3)) bus ();

  cvxif_mac_copro #(.XLEN(32), .NR_ACC(4), .DEPTH(4), .ID_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cvxif  (bus)
  );

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] next_id = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [6:0] f7,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, opc};
  endfunction

  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] id);
    int n = 0;
    while (bus.issue_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("issue_ready_wait", {31'd0, bus.issue_ready}, 32'd1);
    bus.issue_valid = 1'b1;
    bus.issue_instr = instr;
    bus.issue_id    = id;
    bus.issue_rs1   = a;
    bus.issue_rs2   = b;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic commit(input logic [2:0] id, input logic kill);
    bus.commit_valid = 1'b1;
    bus.commit_id    = id;
    bus.commit_kill  = kill;
    @(posedge clk); #1;
    bus.commit_valid = 1'b0;
    bus.commit_kill  = 1'b0;
  endtask

  task automatic expect_res(input logic [2:0] id, input logic [31:0] data, input logic [4:0] rd,
                            input logic we);
    exp_t e;
    e.id = id; e.data = data; e.rd = rd; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] data);
    logic [2:0] id;
    id = next_id;
    next_id = next_id + 3'd1;
    issue(enc(7'h0B, f7, f3, rd), a, b, id);
    expect_res(id, data, rd, (f3 == F_RDL) || (f3 == F_RDH));
    commit(id, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.result_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check(name, {31'd0, bus.result_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got id=%0d data=%h, required no result",
                 bus.result_id, bus.result_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.result_id !== mon_e.id || bus.result_data !== mon_e.data ||
            bus.result_rd !== mon_e.rd || bus.result_we !== mon_e.we) begin
          errors++;
          $display("FAIL result: got id=%0d data=%h rd=%0d we=%b required id=%0d data=%h rd=%0d we=%b",
                   bus.result_id, bus.result_data, bus.result_rd, bus.result_we,
                   mon_e.id, mon_e.data, mon_e.rd, mon_e.we);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.issue_valid  = 1'b0;
    bus.issue_instr  = 32'd0;
    bus.issue_id     = 3'd0;
    bus.issue_rs1    = 32'd0;
    bus.issue_rs2    = 32'd0;
    bus.commit_valid = 1'b0;
    bus.commit_id    = 3'd0;
    bus.commit_kill  = 1'b0;
    bus.result_ready = 1'b1;

    // Reset state
    #12;
    check("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
    check("rst_issue_ready",  {31'd0, bus.issue_ready},  32'd1);
    check("rst_result_data",  bus.result_data,           32'd0);
    check("rst_result_id",    {29'd0, bus.result_id},    32'd0);
    check("rst_result_we",    {31'd0, bus.result_we},    32'd0);
    check("rst_result_rd",    {27'd0, bus.result_rd},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MAC 3 * -4 on acc0, then read both halves; also commit-to-result latency
    issue(enc(7'h0B, 7'd0, F_MAC, 5'd1), 32'd3, 32'hFFFF_FFFC, 3'd0);
    issue(enc(7'h0B, 7'd0, F_RDL, 5'd2), 32'd0, 32'd0, 3'd1);
    issue(enc(7'h0B, 7'd0, F_RDH, 5'd3), 32'd0, 32'd0, 3'd2);
    expect_res(3'd0, 32'd0, 5'd1, 1'b0);
    commit(3'd0, 1'b0);
    check("lat_t0", {31'd0, bus.result_valid}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_t2", {31'd0, bus.result_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_t3", {31'd0, bus.result_valid}, 32'd1);
    expect_res(3'd1, 32'hFFFF_FFF4, 5'd2, 1'b1);
    commit(3'd1, 1'b0);
    expect_res(3'd2, 32'hFFFF_FFFF, 5'd3, 1'b1);
    commit(3'd2, 1'b0);
    drain();

    // Decode
    bus.issue_instr = enc(7'h33, 7'd0, 3'd0, 5'd5); #1;
    check("dec_op33_accept", {31'd0, bus.issue_accept},    32'd0);
    check("dec_op33_wb",     {31'd0, bus.issue_writeback}, 32'd0);
    bus.issue_instr = enc(7'h0B, 7'd1, F_RDL, 5'd5); #1;
    check("dec_rdl_accept",  {31'd0, bus.issue_accept},    32'd1);
    check("dec_rdl_wb",      {31'd0, bus.issue_writeback}, 32'd1);
    bus.issue_instr = enc(7'h0B, 7'd2, F_MAC, 5'd5); #1;
    check("dec_mac_accept",  {31'd0, bus.issue_accept},    32'd1);
    check("dec_mac_wb",      {31'd0, bus.issue_writeback}, 32'd0);
    bus.issue_instr = enc(7'h0B, 7'd0, 3'b100, 5'd5); #1;
    check("dec_f3_4_accept", {31'd0, bus.issue_accept},    32'd0);
    bus.issue_instr = enc(7'h0B, 7'h04, F_MAC, 5'd5); #1;
    check("dec_f7_4_accept", {31'd0, bus.issue_accept},    32'd0);
    @(posedge clk); #1;

    // Rejected instruction is handshaken but leaves the buffer empty
    issue(enc(7'h33, 7'd0, 3'd0, 5'd5), 32'd1, 32'd1, 3'd7);
    repeat (6) @(posedge clk);
    #1;
    check("rej_ready",  {31'd0, bus.issue_ready},  32'd1);
    check("rej_no_res", {31'd0, bus.result_valid}, 32'd0);

    // Fill the buffer; ready drops at 4 entries and returns after the first pop
    issue(enc(7'h0B, 7'd2, F_MAC, 5'd4), 32'd5, 32'd6, 3'd3);
    issue(enc(7'h0B, 7'd2, F_RDL, 5'd5), 32'd0, 32'd0, 3'd4);
    issue(enc(7'h0B, 7'd2, F_CLR, 5'd6), 32'd0, 32'd0, 3'd5);
    issue(enc(7'h0B, 7'd2, F_RDL, 5'd7), 32'd0, 32'd0, 3'd6);
    check("full_ready0", {31'd0, bus.issue_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("full_ready_hold", {31'd0, bus.issue_ready}, 32'd0);
    expect_res(3'd3, 32'd0, 5'd4, 1'b0);
    commit(3'd3, 1'b0);
    wait_valid("full_res_valid");
    check("full_ready_before_pop", {31'd0, bus.issue_ready}, 32'd0);
    @(posedge clk); #1;
    check("full_ready_after_pop", {31'd0, bus.issue_ready}, 32'd1);
    expect_res(3'd4, 32'd30, 5'd5, 1'b1);
    commit(3'd4, 1'b0);
    expect_res(3'd5, 32'd0, 5'd6, 1'b0);
    commit(3'd5, 1'b0);
    expect_res(3'd6, 32'd0, 5'd7, 1'b1);
    commit(3'd6, 1'b0);
    drain();

    // Kill: the killed MAC never touches acc3, only the committed read answers
    issue(enc(7'h0B, 7'd3, F_MAC, 5'd8), 32'd7, 32'd7, 3'd7);
    issue(enc(7'h0B, 7'd3, F_RDL, 5'd9), 32'd0, 32'd0, 3'd0);
    commit(3'd7, 1'b1);
    expect_res(3'd0, 32'd0, 5'd9, 1'b1);
    commit(3'd0, 1'b0);
    drain();
    next_id = 3'd1;

    // Build acc1 = 0x7FFF_FFFF_FFFF_FFFF, then push it over the edge
    run_op(7'd1, F_MAC, 5'd10, 32'h8000_0000, 32'h8000_0000, 32'd0);
    run_op(7'd1, F_MAC, 5'd10, 32'h8000_0000, 32'h8000_0001, 32'd0);
    run_op(7'd1, F_MAC, 5'd10, 32'h7FFF_FFFF, 32'd1, 32'd0);
    run_op(7'd1, F_RDH, 5'd11, 32'd0, 32'd0, 32'h7FFF_FFFF);
    run_op(7'd1, F_RDL, 5'd12, 32'd0, 32'd0, 32'hFFFF_FFFF);
    run_op(7'd1, F_MAC, 5'd10, 32'd1, 32'd1, 32'd0);
`ifdef CVXIF_MAC_SAT_EN
    run_op(7'd1, F_RDH, 5'd11, 32'd0, 32'd0, 32'h7FFF_FFFF);
    run_op(7'd1, F_RDL, 5'd12, 32'd0, 32'd0, 32'hFFFF_FFFF);
`else
    run_op(7'd1, F_RDH, 5'd11, 32'd0, 32'd0, 32'h8000_0000);
    run_op(7'd1, F_RDL, 5'd12, 32'd0, 32'd0, 32'd0);
`endif
    run_op(7'd1, F_CLR, 5'd13, 32'd0, 32'd0, 32'd0);
    run_op(7'd1, F_RDH, 5'd11, 32'd0, 32'd0, 32'd0);
    drain();

    // Reset while holding a response in RESP
    bus.result_ready = 1'b0;
    issue(enc(7'h0B, 7'd0, F_RDL, 5'd14), 32'd0, 32'd0, next_id);
    commit(next_id, 1'b0);
    next_id = next_id + 3'd1;
    wait_valid("hold_valid");
    check("hold_data", bus.result_data, 32'hFFFF_FFF4);
    repeat (2) @(posedge clk);
    #1;
    check("hold_valid_stable", {31'd0, bus.result_valid}, 32'd1);
    check("hold_data_stable",  bus.result_data,           32'hFFFF_FFF4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.result_valid}, 32'd0);
    check("arst_data",  bus.result_data,           32'd0);
    check("arst_ready", {31'd0, bus.issue_ready},  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    run_op(7'd0, F_RDL, 5'd15, 32'd0, 32'd0, 32'd0);
    run_op(7'd0, F_RDH, 5'd16, 32'd0, 32'd0, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
